// File: rtl/rat_ckpt_multi_pkg.sv
// rat_ckpt_multi_pkg: shared sizes, the RAT snapshot type and the CDB wakeup rule
package rat_ckpt_multi_pkg;
    localparam int ARCH_REG_NUM   = 32;
    localparam int DISPATCH_WIDTH = 2;
    localparam int CKPT_NUM       = 4;
    localparam int P_REG_NUM      = 64;
    localparam int CDB_NUM        = 5;
    localparam int PW             = $clog2(P_REG_NUM);
    localparam int CW             = $clog2(CKPT_NUM);

    typedef struct packed {
        logic [ARCH_REG_NUM-1:0][PW-1:0] map;
        logic [ARCH_REG_NUM-1:0]         valid;
    } rat_snap_t;

    // A broadcast only wakes r when its tag is still the one mapped to r
    function automatic rat_snap_t cdb_wake(
        input rat_snap_t                    s,
        input logic [CDB_NUM-1:0][4:0]      rd,
        input logic [CDB_NUM-1:0][PW-1:0]   pd,
        input logic [CDB_NUM-1:0]           we
    );
        rat_snap_t r;
        r = s;
        for (int c = 0; c < CDB_NUM; c++)
            if (we[c] && s.map[rd[c]] == pd[c]) r.valid[rd[c]] = 1'b1;
        return r;
    endfunction

    function automatic rat_snap_t reset_snap();
        rat_snap_t r;
        for (int i = 0; i < ARCH_REG_NUM; i++) r.map[i] = PW'(i);
        r.valid = '1;
        return r;
    endfunction
endpackage

// File: rtl/rat_ckpt_multi_queue.sv
// rat_ckpt_queue: age-ordered circular queue of RAT checkpoints with CDB wakeup and squash
module rat_ckpt_queue
    import rat_ckpt_multi_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        alloc,
    input  rat_snap_t                   alloc_snap,
    input  logic                        resolve,
    input  logic                        mispredict,
    input  logic [CW-1:0]               br_id,
    input  logic [CDB_NUM-1:0][4:0]     rd_cdb,
    input  logic [CDB_NUM-1:0][PW-1:0]  pd_cdb,
    input  logic [CDB_NUM-1:0]          regf_we_cdb,
    output logic [CW-1:0]               tail,
    output logic                        full,
    output rat_snap_t                   restore_snap
);
    rat_snap_t entries [CKPT_NUM];
    logic [CKPT_NUM-1:0] done, done_n;
    logic [CW-1:0] head, rel;
    logic [CW:0] count, pops;
    logic stop;

    assign full = count == (CW+1)'(CKPT_NUM);
    assign rel = br_id - head;
    assign restore_snap = cdb_wake(entries[br_id], rd_cdb, pd_cdb, regf_we_cdb);

    // Retire the run of consecutive done entries starting at head
    always_comb begin
        done_n = done;
        if (resolve && !mispredict) done_n[br_id] = 1'b1;
        pops = '0;
        stop = 1'b0;
        for (int i = 0; i < CKPT_NUM; i++)
            if (!stop && (CW+1)'(i) < count && done_n[head + CW'(i)]) pops = pops + 1'b1;
            else stop = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            done  <= '0;
        end else begin
            done <= done_n;
            for (int i = 0; i < CKPT_NUM; i++)
                entries[i] <= cdb_wake(entries[i], rd_cdb, pd_cdb, regf_we_cdb);
            if (resolve && mispredict) begin
                tail  <= br_id;
                count <= {1'b0, rel};
            end else begin
                head  <= head + pops[CW-1:0];
                count <= count - pops + {{CW{1'b0}}, alloc};
                if (alloc) begin
                    entries[tail] <= alloc_snap;
                    done[tail]    <= 1'b0;
                    tail          <= tail + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk)
        if (!rst && !flush && resolve)
            assert ({1'b0, rel} < count) else $error("br_id %0d is not a live checkpoint", br_id);
endmodule

// File: rtl/rat_ckpt_multi.sv
// rat_ckpt_multi: multi-lane rename RAT with intra-group bypass, CDB wakeup and branch checkpoints
module rat_ckpt_multi
    import rat_ckpt_multi_pkg::*;
(
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic [ARCH_REG_NUM-1:0][PW-1:0]         recover_map,
    input  logic [DISPATCH_WIDTH-1:0][4:0]          rn_rs1,
    input  logic [DISPATCH_WIDTH-1:0][4:0]          rn_rs2,
    input  logic [DISPATCH_WIDTH-1:0][4:0]          rn_rd,
    input  logic [DISPATCH_WIDTH-1:0][PW-1:0]       rn_pd,
    input  logic [DISPATCH_WIDTH-1:0]               rn_we,
    input  logic [DISPATCH_WIDTH-1:0]               rn_br,
    output logic [DISPATCH_WIDTH-1:0][PW-1:0]       ps1,
    output logic [DISPATCH_WIDTH-1:0][PW-1:0]       ps2,
    output logic [DISPATCH_WIDTH-1:0]               ps1_valid,
    output logic [DISPATCH_WIDTH-1:0]               ps2_valid,
    output logic [CW-1:0]                           ckpt_id,
    output logic                                    ckpt_full,
    input  logic [CDB_NUM-1:0][4:0]                 rd_cdb,
    input  logic [CDB_NUM-1:0][PW-1:0]              pd_cdb,
    input  logic [CDB_NUM-1:0]                      regf_we_cdb,
    input  logic                                    br_resolve,
    input  logic [CW-1:0]                           br_id,
    input  logic                                    br_mispredict
);
    rat_snap_t cur, woke, ren_snap, br_snap, restore_snap;
    logic [DISPATCH_WIDTH-1:0][PW-1:0] ps1_n, ps2_n;
    logic [DISPATCH_WIDTH-1:0] ps1v_n, ps2v_n;
    logic restore, alloc;

    assign woke    = cdb_wake(cur, rd_cdb, pd_cdb, regf_we_cdb);
    assign restore = br_resolve && br_mispredict;
    assign alloc   = !flush && !restore && |rn_br && !ckpt_full;

    // Lanes write in order so the youngest wins; the checkpoint sees lanes up to the branch
    always_comb begin
        ren_snap = woke;
        br_snap  = woke;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (rn_we[k] && rn_rd[k] != 5'd0) begin
                ren_snap.map[rn_rd[k]]   = rn_pd[k];
                ren_snap.valid[rn_rd[k]] = 1'b0;
            end
            if (rn_br[k]) br_snap = ren_snap;
        end
    end

    always_comb begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            ps1_n[k]  = woke.map[rn_rs1[k]];
            ps1v_n[k] = woke.valid[rn_rs1[k]];
            ps2_n[k]  = woke.map[rn_rs2[k]];
            ps2v_n[k] = woke.valid[rn_rs2[k]];
            for (int j = 0; j < k; j++) begin
                if (rn_we[j] && rn_rd[j] == rn_rs1[k]) begin
                    ps1_n[k]  = rn_pd[j];
                    ps1v_n[k] = 1'b0;
                end
                if (rn_we[j] && rn_rd[j] == rn_rs2[k]) begin
                    ps2_n[k]  = rn_pd[j];
                    ps2v_n[k] = 1'b0;
                end
            end
            if (rn_rs1[k] == 5'd0) begin
                ps1_n[k]  = '0;
                ps1v_n[k] = 1'b1;
            end
            if (rn_rs2[k] == 5'd0) begin
                ps2_n[k]  = '0;
                ps2v_n[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= reset_snap();
            ps1       <= '0;
            ps2       <= '0;
            ps1_valid <= '0;
            ps2_valid <= '0;
        end else if (flush || restore) begin
            cur       <= flush ? {recover_map, {ARCH_REG_NUM{1'b1}}} : restore_snap;
            ps1       <= '0;
            ps2       <= '0;
            ps1_valid <= '0;
            ps2_valid <= '0;
        end else begin
            cur       <= ren_snap;
            ps1       <= ps1_n;
            ps2       <= ps2_n;
            ps1_valid <= ps1v_n;
            ps2_valid <= ps2v_n;
        end
    end

    always_ff @(posedge clk)
        if (!rst && !flush && !restore) begin
            assert ($onehot0(rn_br)) else $error("more than one branch lane");
            assert (!(|rn_br && ckpt_full)) else $error("branch while checkpoints full");
        end

    rat_ckpt_queue u_q (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .alloc        (alloc),
        .alloc_snap   (br_snap),
        .resolve      (br_resolve),
        .mispredict   (br_mispredict),
        .br_id        (br_id),
        .rd_cdb       (rd_cdb),
        .pd_cdb       (pd_cdb),
        .regf_we_cdb  (regf_we_cdb),
        .tail         (ckpt_id),
        .full         (ckpt_full),
        .restore_snap (restore_snap)
    );
endmodule

// File: tb/tb_rat_ckpt_multi.sv
// tb_rat_ckpt_multi: directed rename, bypass, CDB, checkpoint and flush vectors
module tb_rat_ckpt_multi;
    import rat_ckpt_multi_pkg::*;
    localparam int W = DISPATCH_WIDTH;

    logic clk = 1'b0;
    logic rst, flush, br_resolve, br_mispredict, ckpt_full;
    logic [ARCH_REG_NUM-1:0][PW-1:0] recover_map;
    logic [W-1:0][4:0] rn_rs1, rn_rs2, rn_rd;
    logic [W-1:0][PW-1:0] rn_pd, ps1, ps2;
    logic [W-1:0] rn_we, rn_br, ps1_valid, ps2_valid;
    logic [CW-1:0] ckpt_id, br_id;
    logic [CDB_NUM-1:0][4:0] rd_cdb;
    logic [CDB_NUM-1:0][PW-1:0] pd_cdb;
    logic [CDB_NUM-1:0] regf_we_cdb;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    rat_ckpt_multi dut (
        .clk(clk), .rst(rst), .flush(flush), .recover_map(recover_map),
        .rn_rs1(rn_rs1), .rn_rs2(rn_rs2), .rn_rd(rn_rd), .rn_pd(rn_pd),
        .rn_we(rn_we), .rn_br(rn_br), .ps1(ps1), .ps2(ps2),
        .ps1_valid(ps1_valid), .ps2_valid(ps2_valid), .ckpt_id(ckpt_id),
        .ckpt_full(ckpt_full), .rd_cdb(rd_cdb), .pd_cdb(pd_cdb),
        .regf_we_cdb(regf_we_cdb), .br_resolve(br_resolve), .br_id(br_id),
        .br_mispredict(br_mispredict)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rn_rs1 = '0; rn_rs2 = '0; rn_rd = '0; rn_pd = '0; rn_we = '0; rn_br = '0;
        flush = 1'b0; br_resolve = 1'b0; br_mispredict = 1'b0; br_id = '0;
        rd_cdb = '0; pd_cdb = '0; regf_we_cdb = '0;
    endtask

    task automatic cdb0(input logic [4:0] r, input logic [PW-1:0] p);
        rd_cdb[0] = r; pd_cdb[0] = p; regf_we_cdb[0] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < ARCH_REG_NUM; i++) recover_map[i] = PW'(i + 32);
        idle;
        rst = 1'b1;
        tick;
        tick;
        chk("rst_ps1", ps1[0], 0);
        chk("rst_ps1_valid", ps1_valid, 0);
        chk("rst_full", ckpt_full, 0);
        chk("rst_ckpt_id", ckpt_id, 0);
        rst = 1'b0;

        rn_rs1[0] = 5;
        tick;
        chk("lookup_ps1", ps1[0], 5);
        chk("lookup_valid", ps1_valid[0], 1);

        rn_rs1[0] = 5; rn_rd[0] = 5; rn_pd[0] = 40; rn_we[0] = 1; rn_rs1[1] = 5;
        tick;
        chk("own_rd_no_bypass", ps1[0], 5);
        chk("own_rd_valid", ps1_valid[0], 1);
        chk("bypass_ps1", ps1[1], 40);
        chk("bypass_valid", ps1_valid[1], 0);

        idle;
        rn_rd[0] = 7; rn_pd[0] = 33; rn_rd[1] = 7; rn_pd[1] = 34; rn_we = 2'b11;
        tick;
        idle;
        rn_rs1[0] = 7;
        tick;
        chk("youngest_wins", ps1[0], 34);
        chk("youngest_pending", ps1_valid[0], 0);
        cdb0(7, 33);
        tick;
        chk("stale_cdb_lookup", ps1_valid[0], 0);
        regf_we_cdb = '0;
        tick;
        chk("stale_cdb_kept", ps1_valid[0], 0);
        cdb0(7, 34);
        tick;
        chk("cdb_lookup_wake", ps1_valid[0], 1);
        regf_we_cdb = '0;
        tick;
        chk("cdb_stored_wake", ps1_valid[0], 1);

        idle;
        chk("ckpt_id_before_br", ckpt_id, 0);
        rn_br[0] = 1; rn_rd[1] = 3; rn_pd[1] = 50; rn_we[1] = 1;
        tick;
        chk("ckpt_id_after_br", ckpt_id, 1);
        idle;
        rn_rs1[0] = 3;
        tick;
        chk("live_map3", ps1[0], 50);
        idle;
        br_resolve = 1; br_mispredict = 1; br_id = 0;
        tick;
        chk("restore_tail", ckpt_id, 0);
        chk("restore_count", dut.u_q.count, 0);
        idle;
        rn_rs1[0] = 3;
        tick;
        chk("restored_map3", ps1[0], 3);
        chk("restored_valid3", ps1_valid[0], 1);

        for (int i = 0; i < CKPT_NUM; i++) begin
            idle;
            rn_br[0] = 1;
            chk($sformatf("alloc_id%0d", i), ckpt_id, i);
            tick;
        end
        idle;
        chk("full_after_4", ckpt_full, 1);
        br_resolve = 1; br_id = 1;
        tick;
        chk("full_after_resolve1", ckpt_full, 1);
        br_id = 0;
        tick;
        chk("full_after_resolve0", ckpt_full, 0);
        chk("head_after_resolve0", dut.u_q.head, 2);

        idle;
        br_resolve = 1; br_mispredict = 1; br_id = 2;
        tick;
        idle;
        chk("ckpt_id_reuse", ckpt_id, 2);
        rn_br[0] = 1;
        tick;
        idle;
        tick;
        cdb0(5, 40);
        rn_rd[0] = 5; rn_pd[0] = 41; rn_we[0] = 1;
        tick;
        idle;
        rn_rs1[0] = 5;
        tick;
        chk("live_write_beats_cdb", ps1_valid[0], 0);
        idle;
        br_resolve = 1; br_mispredict = 1; br_id = 2;
        tick;
        idle;
        rn_rs1[0] = 5;
        tick;
        chk("ckpt_cdb_map5", ps1[0], 40);
        chk("ckpt_cdb_valid5", ps1_valid[0], 1);

        idle;
        rn_br[0] = 1;
        tick;
        idle;
        flush = 1; rn_rd[0] = 9; rn_pd[0] = 60; rn_we[0] = 1; rn_br[0] = 1;
        tick;
        chk("flush_ckpt_id", ckpt_id, 0);
        chk("flush_count", dut.u_q.count, 0);
        idle;
        rn_rs1[0] = 9; rn_rs2[0] = 4; rn_rs1[1] = 0;
        tick;
        chk("flush_map9", ps1[0], 41);
        chk("flush_valid9", ps1_valid[0], 1);
        chk("flush_map4", ps2[0], 36);
        chk("flush_valid4", ps2_valid[0], 1);
        chk("x0_map", ps1[1], 0);
        chk("x0_valid", ps1_valid[1], 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
